// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit scheduler.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_ECHO = 1'b1;

  localparam int DEF_BITWIDTH  = 8;
  localparam int DEF_GAP_TICKS = 2;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module      : uart_baud_gen
// Description : Free-running down-counter emitting one baud_tick per
//               baud_val+1 cycles; a new baud_val is picked up on reload.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [BITWIDTH-1:0] baud_val,
  output logic                baud_tick
);

  localparam logic [BITWIDTH-1:0] CNT_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q - CNT_ONE;
    tick_d = 1'b0;
    if (cnt_q == '0) begin
      cnt_d  = baud_val;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baud_tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART TX shifter between the
//               host and echo sources; sequences GRANT/SEND/GAP per byte.
//               UART_ECHO_ARB_EN enables the echo requester.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int BITWIDTH  = DEF_BITWIDTH,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [BITWIDTH-1:0] baud_val,
  output logic                baud_tick,
  input  logic                host_valid,
  input  logic [BITWIDTH-1:0] host_data,
  output logic                host_ready,
  input  logic                echo_valid,
  input  logic [BITWIDTH-1:0] echo_data,
  output logic                echo_ready,
  output logic                tx_start,
  output logic [BITWIDTH-1:0] tx_data,
  input  logic                tx_done,
  output logic                TX_RDY,
  output logic [7:0]          tx_count
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_TICKS);
  localparam logic [3:0] GAP_ONE  = 4'd1;
  localparam logic [7:0] CNT_ONE  = 8'd1;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic [7:0]          count_q, count_d;
  logic [3:0]          gap_q, gap_d;
  logic                w_req_any;
  logic [BITWIDTH-1:0] w_winner_data;

  uart_baud_gen #(
    .BITWIDTH (BITWIDTH)
  ) u_baud_gen (
    .pclk      (pclk),
    .preset    (preset),
    .baud_val  (baud_val),
    .baud_tick (baud_tick)
  );

`ifdef UART_ECHO_ARB_EN
  logic last_q, last_d;
  logic w_winner;

  // On a tie the source that was not served last wins.
  always_comb begin
    w_winner = REQ_HOST;
    if (host_valid && echo_valid) begin
      w_winner = (last_q == REQ_HOST) ? REQ_ECHO : REQ_HOST;
    end else if (echo_valid) begin
      w_winner = REQ_ECHO;
    end
  end

  assign w_req_any     = host_valid | echo_valid;
  assign w_winner_data = (w_winner == REQ_ECHO) ? echo_data : host_data;

  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && w_req_any) begin
      last_d = w_winner;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      last_q <= REQ_ECHO;
    end else begin
      last_q <= last_d;
    end
  end

  assign host_ready = (state_q == ST_GRANT) && (last_q == REQ_HOST);
  assign echo_ready = (state_q == ST_GRANT) && (last_q == REQ_ECHO);
`else
  logic w_unused_echo;

  assign w_unused_echo = ^{echo_valid, echo_data};
  assign w_req_any     = host_valid;
  assign w_winner_data = host_data;
  assign host_ready    = (state_q == ST_GRANT);
  assign echo_ready    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req_any) begin
          state_d = ST_GRANT;
          data_d  = w_winner_data;
        end
      end
      ST_GRANT: state_d = ST_SEND;
      ST_SEND: begin
        if (tx_done) begin
          count_d = count_q + CNT_ONE;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (baud_tick) begin
          gap_d = gap_q - GAP_ONE;
          if (gap_q == GAP_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  assign tx_start = (state_q == ST_GRANT);
  assign tx_data  = data_q;
  assign tx_count = count_q;
  assign TX_RDY   = (state_q == ST_IDLE) && !w_req_any;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched; echo
//               arbitration scenarios follow UART_ECHO_ARB_EN.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_sched;

  logic       pclk       = 1'b0;
  logic       preset     = 1'b1;
  logic [7:0] baud_val   = 8'd1;
  logic       host_valid = 1'b0;
  logic [7:0] host_data  = 8'h00;
  logic       echo_valid = 1'b0;
  logic [7:0] echo_data  = 8'h00;
  logic       tx_done    = 1'b0;
  logic       baud_tick, host_ready, echo_ready, tx_start, TX_RDY;
  logic [7:0] tx_data, tx_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_sched #(.BITWIDTH(8), .GAP_TICKS(2)) dut (
    .pclk       (pclk),
    .preset     (preset),
    .baud_val   (baud_val),
    .baud_tick  (baud_tick),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .echo_valid (echo_valid),
    .echo_data  (echo_data),
    .echo_ready (echo_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .TX_RDY     (TX_RDY),
    .tx_count   (tx_count)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    preset  = 1'b1;
    tx_done = 1'b0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int c = 0;
    while (tx_start !== 1'b1 && c < 50) begin
      @(negedge pclk);
      c++;
    end
    n_tests++;
    if (tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: tx_start=%b after %0d cycles, required 1", tag, tx_start, c);
    end
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (TX_RDY !== 1'b1 && c < 50) begin
      @(negedge pclk);
      c++;
    end
    n_tests++;
    if (TX_RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: TX_RDY=%b after %0d cycles, required 1", tag, TX_RDY, c);
    end
  endtask

  // Called on the GRANT cycle: completes the frame one cycle into SEND.
  task automatic send_done();
    @(negedge pclk);
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1; host_valid = 1'b1; echo_valid = 1'b1;
    host_data = 8'h96; echo_data = 8'h69;
    repeat (2) @(negedge pclk);
    n_tests++;
    if ({tx_start, host_ready, echo_ready, baud_tick, TX_RDY} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: start/hr/er/tick/rdy=%b, required 00000",
               {tx_start, host_ready, echo_ready, baud_tick, TX_RDY});
    end
    n_tests++;
    if (tx_data !== 8'h00 || tx_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_regs: tx_data=%h tx_count=%0d, required 00/0", tx_data, tx_count);
    end
    preset = 1'b0;
    @(negedge pclk);
    n_tests++;
    if (tx_start !== 1'b1 || host_ready !== 1'b1 || echo_ready !== 1'b0 || tx_data !== 8'h96) begin
      n_fail++;
      $display("FAIL reset_first_grant: start=%b hr=%b er=%b data=%h, required 1 1 0 96",
               tx_start, host_ready, echo_ready, tx_data);
    end
    host_valid = 1'b0; echo_valid = 1'b0;
  endtask

  task automatic test_baud();
    logic [11:0] exp_ticks;
    exp_ticks = 12'b1111_0001_0001;
    baud_val = 8'd3;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      n_tests++;
      if (baud_tick !== exp_ticks[i]) begin
        n_fail++;
        $display("FAIL baud_tick[%0d]: got %b, required %b", i, baud_tick, exp_ticks[i]);
      end
      if (i == 5) baud_val = 8'd0;
    end
  endtask

  task automatic test_host_only();
    int  ticks;
    bit  early;
    baud_val = 8'd1;
    do_reset();
    host_valid = 1'b1; host_data = 8'hA5;
    @(negedge pclk);
    n_tests++;
    if (tx_start !== 1'b1 || host_ready !== 1'b1 || echo_ready !== 1'b0 ||
        tx_data !== 8'hA5 || TX_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL host_grant: start=%b hr=%b er=%b data=%h rdy=%b, required 1 1 0 a5 0",
               tx_start, host_ready, echo_ready, tx_data, TX_RDY);
    end
    host_valid = 1'b0;
    @(negedge pclk);
    n_tests++;
    if (tx_start !== 1'b0 || host_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL host_pulse_width: start=%b hr=%b, required 0 0", tx_start, host_ready);
    end
    repeat (8) @(negedge pclk);
    n_tests++;
    if (TX_RDY !== 1'b0 || tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL host_send: rdy=%b data=%h, required 0 a5", TX_RDY, tx_data);
    end
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    n_tests++;
    if (tx_count !== 8'd1 || TX_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL host_done: tx_count=%0d rdy=%b, required 1 0", tx_count, TX_RDY);
    end
    ticks = 0;
    early = 1'b0;
    for (int c = 0; c < 40 && ticks < 2; c++) begin
      if (c > 0) @(negedge pclk);
      if (TX_RDY !== 1'b0) early = 1'b1;
      if (baud_tick === 1'b1) ticks++;
    end
    n_tests++;
    if (early || ticks != 2) begin
      n_fail++;
      $display("FAIL host_gap: early_rdy=%b ticks=%0d, required 0 2", early, ticks);
    end
    @(negedge pclk);
    n_tests++;
    if (TX_RDY !== 1'b1 || tx_count !== 8'd1) begin
      n_fail++;
      $display("FAIL host_idle: rdy=%b tx_count=%0d, required 1 1", TX_RDY, tx_count);
    end
  endtask

`ifdef UART_ECHO_ARB_EN
  task automatic test_tie();
    baud_val = 8'd1;
    host_valid = 1'b1; host_data = 8'h11;
    echo_valid = 1'b1; echo_data = 8'h22;
    do_reset();
    wait_grant("tie1_grant");
    n_tests++;
    if (tx_data !== 8'h11 || host_ready !== 1'b1 || echo_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tie1: data=%h hr=%b er=%b, required 11 1 0", tx_data, host_ready, echo_ready);
    end
    host_valid = 1'b0;
    send_done();
    wait_grant("tie2_grant");
    n_tests++;
    if (tx_data !== 8'h22 || host_ready !== 1'b0 || echo_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie2: data=%h hr=%b er=%b, required 22 0 1", tx_data, host_ready, echo_ready);
    end
    echo_valid = 1'b0;
    send_done();
    wait_idle("tie2_idle");
    host_valid = 1'b1; host_data = 8'h33;
    echo_valid = 1'b1; echo_data = 8'h44;
    wait_grant("tie3_grant");
    n_tests++;
    if (tx_data !== 8'h33 || host_ready !== 1'b1 || echo_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tie3: data=%h hr=%b er=%b, required 33 1 0", tx_data, host_ready, echo_ready);
    end
    host_valid = 1'b0;
    send_done();
    wait_grant("tie4_grant");
    n_tests++;
    if (tx_data !== 8'h44 || echo_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tie4: data=%h er=%b, required 44 1", tx_data, echo_ready);
    end
    echo_valid = 1'b0;
    send_done();
    wait_idle("tie4_idle");
    n_tests++;
    if (tx_count !== 8'd4) begin
      n_fail++;
      $display("FAIL tie_count: tx_count=%0d, required 4", tx_count);
    end
  endtask
`else
  task automatic test_echo_ignored();
    bit bad_er, bad_start, bad_rdy;
    baud_val = 8'd1;
    host_valid = 1'b0;
    echo_valid = 1'b1; echo_data = 8'h5A;
    do_reset();
    bad_er = 1'b0; bad_start = 1'b0; bad_rdy = 1'b0;
    repeat (20) begin
      @(negedge pclk);
      if (echo_ready !== 1'b0) bad_er = 1'b1;
      if (tx_start !== 1'b0) bad_start = 1'b1;
      if (TX_RDY !== 1'b1) bad_rdy = 1'b1;
    end
    n_tests++;
    if (bad_er || bad_start || bad_rdy) begin
      n_fail++;
      $display("FAIL echo_ignored: er_seen=%b start_seen=%b rdy_low_seen=%b, required 0 0 0",
               bad_er, bad_start, bad_rdy);
    end
    host_valid = 1'b1; host_data = 8'h3C;
    wait_grant("echo_ignored_host_grant");
    n_tests++;
    if (tx_data !== 8'h3C || host_ready !== 1'b1 || echo_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL echo_ignored_host: data=%h hr=%b er=%b, required 3c 1 0",
               tx_data, host_ready, echo_ready);
    end
    host_valid = 1'b0; echo_valid = 1'b0;
    send_done();
    wait_idle("echo_ignored_idle");
  endtask
`endif

  task automatic test_reset_mid_send();
    bit bad;
    baud_val = 8'd1;
    host_valid = 1'b0; echo_valid = 1'b0;
    do_reset();
    host_valid = 1'b1; host_data = 8'hC3;
    wait_grant("mid_first_grant");
    host_valid = 1'b0;
    send_done();
    wait_idle("mid_first_idle");
    n_tests++;
    if (tx_count !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_pre_count: tx_count=%0d, required 1", tx_count);
    end
    host_valid = 1'b1; host_data = 8'h7E;
    wait_grant("mid_second_grant");
    host_valid = 1'b0;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    n_tests++;
    if (TX_RDY !== 1'b1 || tx_count !== 8'd0 || tx_data !== 8'h00 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rdy=%b count=%0d data=%h start=%b, required 1 0 00 0",
               TX_RDY, tx_count, tx_data, tx_start);
    end
    preset  = 1'b0;
    tx_done = 1'b1;
    @(negedge pclk);
    tx_done = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (host_ready !== 1'b0 || tx_start !== 1'b0 || tx_count !== 8'd0 || TX_RDY !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL mid_late_done: hr=%b start=%b count=%0d rdy=%b, required 0 0 0 1",
               host_ready, tx_start, tx_count, TX_RDY);
    end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_host_only();
`ifdef UART_ECHO_ARB_EN
    test_tie();
`else
    test_echo_ignored();
`endif
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
